// File: rtl/ram_stream_out_if.sv
// ram_stream_out_if: bundles the signals of ram_stream_out other than clock and reset.
//   Avalon-MM slave: address[2:0], write, writedata[31:0], read, readdata[31:0]
//   RAM C read port: addr_c[10:0] (address out), q_c[31:0] (data back, 1-cycle latency)
//   Output stream:   out_data[31:0], out_valid, out_ready, out_last
// The slave modport is the drain block's view. The master modport is the view of
// the host, RAM and sink surrounding it.
interface ram_stream_out_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [10:0] addr_c;
    logic [31:0] q_c;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport slave (
        input  address, write, writedata, read, q_c, out_ready,
        output readdata, addr_c, out_data, out_valid, out_last
    );

    modport master (
        output address, write, writedata, read, q_c, out_ready,
        input  readdata, addr_c, out_data, out_valid, out_last
    );
endinterface

// File: rtl/ram_stream_out.sv
// ram_stream_out: reads a host-programmed window of result RAM C and emits it as a
// valid/ready stream, with a last-beat marker. Up to one word per clock is
// sustained despite the one-cycle RAM read latency, using a 2-entry output buffer.
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : ram_stream_out_if.slave (Avalon registers, RAM C read port, output stream)
// Registers:
//   0 go/status (write bit0: start or abort; read {done,busy})
//   1 start address
//   2 length (clamped to 2048)
//   3 accepted beat count
//   4 ID
module ram_stream_out (
    input  logic            clock,
    input  logic            reset,
    ram_stream_out_if.slave bus
);
    localparam logic [31:0] ID_VALUE = 32'h5354524D;
    localparam logic [11:0] MAX_LEN  = 12'd2048;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] start_q;
    logic [11:0] length_q;
    logic [11:0] beats_q;
    logic [11:0] issued_q;
    logic [10:0] issue_addr_q;
    logic        inflight_q;
    logic [31:0] fifo_mem [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  fifo_count_q;
    logic [31:0] readdata_q;

    logic        busy;
    logic        done;
    logic        go_wr;
    logic        start_run;
    logic        abort_run;
    logic        pop;
    logic        issue;
    logic [2:0]  occupancy;

    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        go_wr     = bus.write && (bus.address == 3'd0);
        start_run = go_wr && bus.writedata[0] && !busy;
        abort_run = go_wr && !bus.writedata[0] && busy;
        pop       = bus.out_valid && bus.out_ready;
        // A word in flight from the RAM has a reserved buffer slot. A slot that
        // frees up this cycle is reusable at once, so back-to-back issue continues
        // while the sink accepts every cycle.
        occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = busy && !abort_run && (issued_q < length_q) && (occupancy < 3'd2);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort_run) begin
                    state_d = ST_IDLE;
                end else if ((length_q == 12'd0) || (pop && bus.out_last)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_q      <= '0;
            length_q     <= '0;
            beats_q      <= '0;
            issued_q     <= '0;
            issue_addr_q <= '0;
            inflight_q   <= 1'b0;
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            fifo_count_q <= '0;
            readdata_q   <= '0;
        end else begin
            if (start_run) begin
                beats_q      <= '0;
                issued_q     <= '0;
                issue_addr_q <= start_q;
                inflight_q   <= 1'b0;
                rd_ptr_q     <= 1'b0;
                wr_ptr_q     <= 1'b0;
                fifo_count_q <= '0;
            end else if (abort_run) begin
                // Abort discards buffered and in-flight words. The beat count keeps its value.
                inflight_q   <= 1'b0;
                rd_ptr_q     <= 1'b0;
                wr_ptr_q     <= 1'b0;
                fifo_count_q <= '0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    issue_addr_q <= issue_addr_q + 11'd1;
                    issued_q     <= issued_q + 12'd1;
                end
                if (inflight_q) begin
                    fifo_mem[wr_ptr_q] <= bus.q_c;
                    wr_ptr_q           <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                    beats_q  <= beats_q + 12'd1;
                end
                fifo_count_q <= fifo_count_q + {1'b0, inflight_q} - {1'b0, pop};
            end

            if (bus.write && !busy) begin
                case (bus.address)
                    3'd1: start_q <= bus.writedata[10:0];
                    3'd2: length_q <= (bus.writedata > 32'd2048) ? MAX_LEN
                                                                : bus.writedata[11:0];
                    default: ;
                endcase
            end

            if (bus.read) begin
                case (bus.address)
                    3'd0:    readdata_q <= {30'b0, done, busy};
                    3'd1:    readdata_q <= {21'b0, start_q};
                    3'd2:    readdata_q <= {20'b0, length_q};
                    3'd3:    readdata_q <= {20'b0, beats_q};
                    3'd4:    readdata_q <= ID_VALUE;
                    default: readdata_q <= readdata_q;
                endcase
            end
        end
    end

    assign bus.readdata  = readdata_q;
    assign bus.addr_c    = issue_addr_q;
    assign bus.out_valid = (fifo_count_q != 2'd0);
    assign bus.out_data  = fifo_mem[rd_ptr_q];
    // Beats leave in order, so the head is always beat number beats_q.
    assign bus.out_last  = bus.out_valid && (beats_q == length_q - 12'd1);
endmodule

// File: tb/tb_ram_stream_out.sv
// tb_ram_stream_out: drives ram_stream_out through its register interface, with a
// behavioural RAM C and a ready driver (held or random). It keeps a queue of
// expected beats built from the RAM contents and the window rules, and checks
// every accepted beat against that queue.
`timescale 1ns/1ps
module tb_ram_stream_out;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ram_stream_out_if bus ();

    ram_stream_out dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mem [2048];
    beat_t       exp_q [$];
    logic [10:0] addr_log [$];
    logic [10:0] addr_prev = '0;
    int          pops = 0;
    logic        rnd_mode = 1'b0;
    logic        ready_val = 1'b0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;
    logic        hold_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    // RAM C: registered read, one cycle of latency
    always @(posedge clock) bus.q_c <= mem[bus.addr_c];

    // Sink ready, updated just after each edge
    always @(posedge clock) begin
        #2;
        bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end

    always @(posedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) pops <= pops + 1;
    end

    always @(negedge clock) begin
        if (bus.addr_c != addr_prev) begin
            addr_log.push_back(bus.addr_c);
            addr_prev = bus.addr_c;
        end
    end

    // Compare process: every beat against the model, hold-stability under backpressure
    always @(negedge clock) begin
        beat_t e;
        if (!reset) begin
            if (hold_pending && bus.out_valid) begin
                chk("hold_data", bus.out_data, hold_data);
                chk("hold_last", 32'(bus.out_last), 32'(hold_last));
            end
            hold_pending = 1'b0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(bus.out_valid), 32'd0);
                end else if (bus.out_ready) begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.out_data, e.data);
                    chk("beat_last", 32'(bus.out_last), 32'(e.last));
                end else begin
                    hold_pending = 1'b1;
                    hold_data    = bus.out_data;
                    hold_last    = bus.out_last;
                end
            end
        end
    end

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(posedge clock); #1;
        bus.write = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a; bus.read = 1'b1;
        @(posedge clock); #1;
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic launch(input int st, input int len);
        reg_write(3'd1, 32'(st));
        reg_write(3'd2, 32'(len));
        for (int i = 0; i < len; i++)
            exp_q.push_back('{data: mem[(st + i) % 2048], last: (i == len - 1)});
        reg_write(3'd0, 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles, input string nm);
        for (int k = 0; k < max_cycles; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clock); #1;
        end
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          st;
        int          base;

        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = (i < 8) ? 32'(i * 3) : $urandom;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_readdata", bus.readdata, 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_addr_c", 32'(bus.addr_c), 32'd0);
        reg_read(3'd0, rd); chk("rst_status", rd, 32'd0);
        reg_read(3'd4, rd); chk("id", rd, 32'h5354524D);
        reg_read(3'd7, rd); chk("unmapped_holds", rd, 32'h5354524D);

        // Run 1: start 0, length 8, sink always ready; beats 0,3,...,21 back to back
        ready_val = 1'b1;
        @(posedge clock); #1;
        launch(0, 8);
        chk("lat_e0_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clock); #1;
        chk("lat_e1_valid", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            chk("run1_valid", 32'(bus.out_valid), 32'd1);
            chk("run1_literal", bus.out_data, 32'(k * 3));
            chk("run1_last", 32'(bus.out_last), 32'(k == 7));
        end
        @(posedge clock); #1;
        chk("run1_end_valid", 32'(bus.out_valid), 32'd0);
        wait_idle(50, "run1");
        reg_read(3'd3, rd); chk("run1_beats", rd, 32'd8);
        reg_read(3'd0, rd); chk("run1_status", rd, 32'd2);

        // Run 2: window wraps past the top of RAM
        addr_log.delete();
        launch(2046, 4);
        wait_idle(50, "wrap");
        chk("wrap_log_len", 32'(addr_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < addr_log.size()) chk("wrap_addr_c", 32'(addr_log[i]), 32'((2046 + i) % 2048));

        // Run 3: same as run 1 with random backpressure
        rnd_mode = 1'b1;
        launch(0, 8);
        wait_idle(400, "bp");
        rnd_mode = 1'b0;
        reg_read(3'd3, rd); chk("bp_beats", rd, 32'd8);
        reg_read(3'd0, rd); chk("bp_status", rd, 32'd2);

        // Random windows with random backpressure
        for (int r = 0; r < 4; r++) begin
            rnd_mode = 1'b1;
            launch($urandom_range(0, 2047), $urandom_range(1, 40));
            wait_idle(1000, "rand");
            rnd_mode = 1'b0;
        end

        // Length 0: busy for one cycle, then done, no beats; length clamp
        reg_write(3'd2, 32'd0);
        reg_write(3'd0, 32'd1);
        reg_read(3'd0, rd); chk("len0_busy", rd, 32'd1);
        reg_read(3'd0, rd); chk("len0_done", rd, 32'd2);
        repeat (4) @(posedge clock); #1;
        reg_write(3'd2, 32'd5000);
        reg_read(3'd2, rd); chk("len_clamp", rd, 32'd2048);

        // Abort after 10 accepted beats; register writes during the run are ignored
        st = $urandom_range(0, 2047);
        base = pops;
        launch(st, 100);
        reg_write(3'd1, 32'd5);
        reg_write(3'd2, 32'd7);
        for (int k = 0; k < 500; k++) begin
            if (pops - base >= 10) break;
            @(posedge clock); #1;
        end
        chk("abort_reached", 32'(pops - base), 32'd10);
        ready_val = 1'b0;
        reg_write(3'd0, 32'd0);
        exp_q.delete();
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        reg_read(3'd0, rd); chk("abort_status", rd, 32'd0);
        reg_read(3'd3, rd); chk("abort_beats", rd, 32'd10);
        reg_read(3'd1, rd); chk("busy_start_ignored", rd, 32'(st));
        reg_read(3'd2, rd); chk("busy_len_ignored", rd, 32'd100);
        ready_val = 1'b1;
        repeat (3) @(posedge clock); #1;
        chk("abort_quiet", 32'(bus.out_valid), 32'd0);

        // Reset mid-run, then a clean run of 3
        launch(0, 50);
        repeat (6) @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_last", 32'(bus.out_last), 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        chk("mid_rst_addr_c", 32'(bus.addr_c), 32'd0);
        chk("mid_rst_readdata", bus.readdata, 32'd0);
        reg_read(3'd0, rd); chk("mid_rst_status", rd, 32'd0);
        launch(5, 3);
        wait_idle(50, "post_rst");
        reg_read(3'd3, rd); chk("post_rst_beats", rd, 32'd3);
        reg_read(3'd0, rd); chk("post_rst_status", rd, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_stream_out.md
# ram_stream_out

Downstream drain stage for the simple-add datapath: once the adder has filled result RAM C, this block reads a host-programmed window of RAM C through its read port and emits the words as a valid/ready stream with a last-beat marker. It is an Avalon-MM slave (go/status, start address, length, beat counter, ID) and supports full throughput of one word per clock despite the RAM's one-cycle read latency, using a 2-entry output buffer.

## Interface
- No parameters; widths fixed: RAM depth 2048 words, 32-bit data.
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- address  in  3  Avalon register index
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe
- readdata  out  32  registered read data
- addr_c  out  11  RAM C read address
- q_c  in  32  RAM C read data, valid one cycle after addr_c is sampled
- out_data  out  32  stream word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_last  out  1  high with final beat of a run

## Operation
- Registers (write / read):
  - 0: write bit0=1 starts run (ignored while busy); bit0=0 while busy aborts. Read {30'b0, done, busy}.
  - 1: start address, writedata[10:0]; ignored while busy. Reads back zero-extended.
  - 2: length, writedata[11:0], values >2048 stored as 2048; ignored while busy. Reads back.
  - 3: read-only, beats accepted in current/last run (12 bits, zero-extended).
  - 4: read-only ID 32'h5354524D. Other addresses: readdata holds.
- Start: busy<=1, done<=0, beat counter<=0, issue address<=start, issued count<=0. Length 0: busy clears next edge, done<=1, no beats.
- Issue: a read is issued in a cycle when issued<length and (fifo_count + inflight − pop) < 2, pop = out_valid && out_ready. Issue sets inflight for the next cycle and increments issue address (11-bit wrap 2047→0) and issued count.
- addr_c always equals the issue-address register (changes only on issue).
- Capture: when inflight, q_c is pushed into the FIFO at the next edge. FIFO never overflows by construction.
- Output: out_valid = fifo not empty; out_data = head; out_last = head is beat number length−1.
- Completion: at the edge accepting the last beat, busy<=0, done<=1.
- Abort: stop issuing, flush FIFO, drop inflight; busy<=0 at the next edge, done stays 0, beat counter frozen.
- Read and write in the same cycle are both performed; readdata shows pre-write value.
- Reset values: readdata=0, addr_c=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, length=0, start=0, beat count=0.

## Timing
- readdata valid the cycle after the edge sampling read.
- Go sampled at edge E0 → first addr_c issue in cycle after E0 → RAM samples at E1 → FIFO captures at E2 → out_valid high after E2 (3-edge latency).
- With out_ready held high: one beat per cycle thereafter, length beats in length consecutive cycles.
- out_ready low: FIFO fills to 2, issue stalls; no beat lost or duplicated; out_data/out_last stable while out_valid && !out_ready.
- Reset mid-run: all outputs to reset values at that edge; a subsequent run starts cleanly.

## Test plan
- RAM C[i]=i*3 for i=0..7; start=0, length=8, out_ready=1 → beats 0,3,...,21 on 8 consecutive cycles starting 3 edges after go; out_last only on 21; reg3=8, status=2'b10.
- start=2046, length=4 → addr_c sequence 2046,2047,0,1; data matches those locations.
- Same as first run with out_ready toggling pseudo-randomly → identical sequence, no drops/duplicates, data held stable under backpressure.
- length=0 → no out_valid ever; status busy then done within 2 cycles; length=5000 → reads back 2048.
- Abort: length=100, write go=0 after 10 accepted beats → out_valid low next cycle, busy=0, done=0, reg3=10; writes to regs 1/2 during run ignored.
- Assert reset mid-run → out_valid=0, status=0, readdata=0 next cycle; new run of length 3 completes correctly.
